// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
// Module   : return_stack
// Purpose  : Return-address stack for the single-cycle CPU. JAL pushes the
//            return PC and JR pops it. The top entry feeds the PC-source mux.
//            Overflow and underflow are reported by sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module return_stack #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              push,
    input  logic              pop,
    input  logic              halted,
    input  logic [ADDR_W-1:0] ret_addr,
    output logic [ADDR_W-1:0] top,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0]   c_DEPTH   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] c_IDX_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]    r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_act;
    logic              w_do_push;
    logic              w_do_replace;
    logic              w_do_pop;
    logic              w_set_ovf;
    logic              w_set_udf;
    logic [PTR_W-1:0]  w_top_idx;
    logic [PTR_W-1:0]  w_wr_idx;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    // When full the low bits of count are zero, so subtracting one lands on DEPTH-1.
    assign w_top_idx = r_count[PTR_W-1:0] - c_IDX_ONE;

    // Halted freezes every state update; push & pop on an empty stack degrades to a push.
    assign w_act        = ~halted;
    assign w_do_push    = w_act & push & (~pop | w_empty) & ~w_full;
    assign w_do_replace = w_act & push & pop & ~w_empty;
    assign w_do_pop     = w_act & pop & ~push & ~w_empty;
    assign w_set_ovf    = w_act & push & ~pop & w_full;
    assign w_set_udf    = w_act & pop & ~push & w_empty;
    assign w_wr_idx     = w_do_replace ? w_top_idx : r_count[PTR_W-1:0];

    // Storage array: written on push or replace, never cleared by reset.
    always_ff @(posedge clk) begin
        if (w_do_push || w_do_replace) begin
            r_mem[w_wr_idx] <= ret_addr;
        end
    end

    // Entry count and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_do_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_set_udf) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign top       = w_empty ? '0 : r_mem[w_top_idx];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_return_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_return_stack
// Purpose  : Self-checking bench for return_stack: directed vector table,
//            hand-written corner sequences and a randomized run against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_return_stack;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              push, pop, halted;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] top;
    logic [PTR_W:0]    count;
    logic              empty, full, overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stack contents as a queue, flags as bits.
    logic [ADDR_W-1:0] m_stk [$];
    bit                m_ovf;
    bit                m_udf;

    typedef struct {
        bit                push;
        bit                pop;
        bit                halted;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] exp_top;
        int                exp_count;
        bit                exp_empty;
        bit                exp_full;
        bit                exp_ovf;
        bit                exp_udf;
    } vec_t;

    vec_t vecs [$];

    return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .halted(halted),
        .ret_addr(ret_addr), .top(top), .count(count), .empty(empty),
        .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] m_top();
        return (m_stk.size() == 0) ? '0 : m_stk[m_stk.size()-1];
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, ".top"},   32'(top),       32'(m_top()));
        chk({tag, ".count"}, 32'(count),     32'(m_stk.size()));
        chk({tag, ".empty"}, 32'(empty),     32'(m_stk.size() == 0));
        chk({tag, ".full"},  32'(full),      32'(m_stk.size() == DEPTH));
        chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
        chk({tag, ".udf"},   32'(underflow), 32'(m_udf));
    endtask

    task automatic model_step(input bit p, input bit q, input bit h, input logic [ADDR_W-1:0] a);
        if (!h) begin
            if (p && q && m_stk.size() > 0) begin
                m_stk[m_stk.size()-1] = a;
            end else if (p) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(a);
                else m_ovf = 1'b1;
            end else if (q) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_udf = 1'b1;
            end
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic do_cycle(input bit p, input bit q, input bit h, input logic [ADDR_W-1:0] a,
                            input string tag);
        push = p; pop = q; halted = h; ret_addr = a;
        #1;
        chk_model(tag);
        @(posedge clk);
        model_step(p, q, h, a);
        @(negedge clk);
        push = 1'b0; pop = 1'b0; halted = 1'b0;
    endtask

    task automatic apply_reset();
        push = 1'b0; pop = 1'b0; halted = 1'b0; ret_addr = '0;
        reset = 1'b0;
        m_stk.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        #2;
        chk("rst.count", 32'(count), 0);
        chk("rst.empty", 32'(empty), 1);
        chk("rst.full",  32'(full),  0);
        chk("rst.top",   32'(top),   0);
        chk("rst.ovf",   32'(overflow), 0);
        chk("rst.udf",   32'(underflow), 0);
        reset = 1'b1;
        @(negedge clk);
    endtask

    function automatic vec_t mk(bit p, bit q, bit h, int a, int et, int ec,
                                bit ee, bit ef, bit eo, bit eu);
        vec_t v;
        v.push = p; v.pop = q; v.halted = h; v.addr = ADDR_W'(a);
        v.exp_top = ADDR_W'(et); v.exp_count = ec; v.exp_empty = ee;
        v.exp_full = ef; v.exp_ovf = eo; v.exp_udf = eu;
        return v;
    endfunction

    initial begin
        reset = 1'b0; push = 1'b0; pop = 1'b0; halted = 1'b0; ret_addr = '0;

        // Expected values are the outputs after the edge that applies each vector.
        //            p  q  h  addr   top    cnt e  f  o  u
        vecs.push_back(mk(1, 1, 0, 'h077, 'h077, 1, 0, 0, 0, 0)); // push&pop on empty = push
        vecs.push_back(mk(0, 1, 0, 'h000, 'h000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 'h005, 'h005, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 'h00A, 'h00A, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 'h0F3, 'h0F3, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 'h000, 'h00A, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 'h000, 'h005, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 'h000, 'h000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 'h000, 'h000, 0, 1, 0, 0, 1)); // underflow
        vecs.push_back(mk(1, 0, 0, 'h123, 'h123, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 'h010, 'h010, 2, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 'h020, 'h020, 2, 0, 0, 0, 1)); // replace top
        vecs.push_back(mk(1, 0, 1, 'h3FF, 'h020, 2, 0, 0, 0, 1)); // halted
        vecs.push_back(mk(0, 1, 1, 'h000, 'h020, 2, 0, 0, 0, 1)); // halted
        vecs.push_back(mk(0, 1, 0, 'h000, 'h123, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 'h055, 'h055, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 'h000, 'h000, 0, 1, 0, 0, 1));

        @(negedge clk);
        apply_reset();

        // Directed vector table.
        foreach (vecs[i]) begin
            do_cycle(vecs[i].push, vecs[i].pop, vecs[i].halted, vecs[i].addr, $sformatf("vec%0d.pre", i));
            chk($sformatf("vec%0d.top", i),   32'(top),       32'(vecs[i].exp_top));
            chk($sformatf("vec%0d.count", i), 32'(count),     32'(vecs[i].exp_count));
            chk($sformatf("vec%0d.empty", i), 32'(empty),     32'(vecs[i].exp_empty));
            chk($sformatf("vec%0d.full", i),  32'(full),      32'(vecs[i].exp_full));
            chk($sformatf("vec%0d.ovf", i),   32'(overflow),  32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d.udf", i),   32'(underflow), 32'(vecs[i].exp_udf));
        end

        // Fill to DEPTH, then one extra push.
        apply_reset();
        for (int i = 0; i < DEPTH; i++) do_cycle(1, 0, 0, ADDR_W'(i), "fill");
        chk("fill.full",  32'(full),  1);
        chk("fill.top",   32'(top),   15);
        chk("fill.count", 32'(count), 16);
        do_cycle(1, 0, 0, ADDR_W'(16), "ovf");
        chk("ovf.flag",  32'(overflow), 1);
        chk("ovf.count", 32'(count),    16);
        chk("ovf.top",   32'(top),      15);
        do_cycle(0, 1, 0, '0, "popfull");
        chk("popfull.top",   32'(top),   14);
        chk("popfull.count", 32'(count), 15);
        for (int i = 0; i < DEPTH - 1; i++) do_cycle(0, 1, 0, '0, "drain");
        do_cycle(0, 1, 0, '0, "udf");
        chk("udf.flag", 32'(underflow), 1);
        do_cycle(1, 0, 0, 'h1A1, "p1");
        do_cycle(1, 0, 0, 'h1A2, "p2");
        chk("flags.ovf", 32'(overflow), 1);

        // Halted with push/pop pulses must leave everything untouched.
        do_cycle(1, 0, 1, 'h3C3, "halt1");
        do_cycle(0, 1, 1, 'h000, "halt2");
        do_cycle(1, 1, 1, 'h2B2, "halt3");
        chk("halt.count", 32'(count), 2);
        chk("halt.top",   32'(top),   'h1A2);

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b0;
        #1;
        chk("areset.count", 32'(count),     0);
        chk("areset.ovf",   32'(overflow),  0);
        chk("areset.udf",   32'(underflow), 0);
        chk("areset.empty", 32'(empty),     1);
        chk("areset.top",   32'(top),       0);
        m_stk.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        do_cycle(0, 0, 0, '0, "post_areset");

        // Randomized run against the reference model, with a drifting push bias.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            int bias;
            int r;
            bit p, q, h;
            bias = ((i / 150) % 2 == 0) ? 65 : 30;
            r = int'($urandom_range(0, 99));
            p = (r < bias);
            q = (int'($urandom_range(0, 99)) < (100 - bias));
            h = ($urandom_range(0, 9) == 0);
            do_cycle(p, q, h, ADDR_W'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
